conv_pixel_feeder: RTL and testbench

CONV_PIXEL_FEEDER -- requirements
Module: conv_pixel_feeder

---
 rtl/conv_pixel_feeder.sv | 129 ++++++++++++
 tb/tb_conv_pixel_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pixel_feeder.sv
// Frame buffer with a host write port that streams one stored frame, in raster
// order, to a convolution engine per go request, then waits for its done pulse.
module conv_pixel_feeder #(
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32,
  parameter int DONE_TIMEOUT = 64,
  localparam int N  = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          go,
  input  logic          hold,
  input  logic          conv_done,
  output logic          start_signal,
  output logic [7:0]    pixel_out,
  output logic          pixel_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic          wr_err,
  output logic [1:0]    dbg_state
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_STREAM    = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(DONE_TIMEOUT - 1);

  logic [7:0]    r_mem [0:N-1];
  logic [1:0]    r_state;
  logic [AW-1:0] r_rd_addr;
  logic [TW-1:0] r_wait_cnt;
  logic [7:0]    r_pixel;
  logic          r_valid;
  logic          r_start;
  logic          r_frame_done;
  logic          r_frame_err;
  logic          r_wr_err;
  logic          w_busy;

  assign w_busy = (r_state != S_IDLE);

  // Host writes land only while idle, so a streaming frame is never torn.
  always_ff @(posedge clk) begin
    if (wr_en && !w_busy) r_mem[wr_addr] <= wr_data;
  end

  // Handshake: pixel_valid qualifies pixel_out for exactly one cycle per pixel;
  // there is no ready, hold=1 sampled at an edge simply skips that edge's pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rd_addr    <= '0;
      r_wait_cnt   <= '0;
      r_pixel      <= '0;
      r_valid      <= 1'b0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_wr_err     <= wr_en && w_busy;
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (go) begin
            r_state   <= S_START;
            r_rd_addr <= '0;
            r_start   <= 1'b1;
          end
        end
        S_START: begin
          r_valid <= 1'b0;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (hold) begin
            r_valid <= 1'b0;
          end else begin
            r_pixel <= r_mem[r_rd_addr];
            r_valid <= 1'b1;
            // The last address is issued here; the counter parks instead of wrapping.
            if (r_rd_addr == LAST_ADDR) begin
              r_state    <= S_WAIT_DONE;
              r_wait_cnt <= '0;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        S_WAIT_DONE: begin
          r_valid <= 1'b0;
          if (conv_done) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end else if (r_wait_cnt == TO_LAST) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_signal = r_start;
  assign pixel_out    = r_pixel;
  assign pixel_valid  = r_valid;
  assign busy         = w_busy;
  assign frame_done   = r_frame_done;
  assign frame_err    = r_frame_err;
  assign wr_err       = r_wr_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Bench for conv_pixel_feeder: frames are captured by a driver task and checked
// against a reference frame buffer and the latency/handshake rules.
module tb_conv_pixel_feeder;

  localparam int N       = 1024;
  localparam int AW      = 10;
  localparam int TIMEOUT = 64;
  localparam int BUDGET  = 4 * N;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          go;
  logic          hold;
  logic          conv_done;
  logic          start_signal;
  logic [7:0]    pixel_out;
  logic          pixel_valid;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic          wr_err;
  logic [1:0]    dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [N];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];

  // scenario knobs for collect_frame
  int cfg_hold_at, cfg_hold_len, cfg_done_delay, cfg_busy_wr_at;
  bit cfg_rand_hold, cfg_noise, cfg_wr_with_go;
  logic [AW-1:0] cfg_wr_addr;
  logic [7:0]    cfg_wr_data;

  // observations of the last collected frame
  int obs_start_at_go, obs_start_cnt, obs_first_cyc, obs_gap;
  int obs_done_cnt, obs_err_cnt, obs_done_rel, obs_err_rel, obs_wr_err_cnt;
  int obs_busy_at_done, obs_timeout;

  conv_pixel_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .go           (go),
    .hold         (hold),
    .conv_done    (conv_done),
    .start_signal (start_signal),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .wr_err       (wr_err),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_defaults();
    cfg_hold_at    = -1;
    cfg_hold_len   = 0;
    cfg_done_delay = 4;
    cfg_busy_wr_at = -1;
    cfg_rand_hold  = 0;
    cfg_noise      = 0;
    cfg_wr_with_go = 0;
    cfg_wr_addr    = '0;
    cfg_wr_data    = '0;
  endtask

  task automatic load_frame(input bit rand_data);
    for (int i = 0; i < N; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = rand_data ? 8'($urandom) : 8'(i % 256);
      ref_mem[i] = wr_data;
      tick();
    end
    wr_en = 1'b0;
  endtask

  function automatic void build_expected();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(ref_mem[i]);
  endfunction

  // Pulses go, drives hold/noise/conv_done per the cfg knobs, and records what came out.
  task automatic collect_frame();
    int cyc, rel, nvalid, hold_left;
    bit wr_done;
    obs_q.delete();
    obs_start_cnt = 0; obs_first_cyc = -1; obs_gap = 0;
    obs_done_cnt = 0; obs_err_cnt = 0; obs_done_rel = -1; obs_err_rel = -1;
    obs_wr_err_cnt = 0; obs_busy_at_done = -1; obs_timeout = 0;
    cyc = 0; rel = -1; nvalid = 0; hold_left = 0; wr_done = 0;
    go = 1'b1;
    if (cfg_wr_with_go) begin
      wr_en = 1'b1; wr_addr = cfg_wr_addr; wr_data = cfg_wr_data;
      ref_mem[cfg_wr_addr] = cfg_wr_data;
    end
    tick();
    go = 1'b0; wr_en = 1'b0;
    obs_start_at_go = int'(start_signal);
    obs_start_cnt  += int'(start_signal);
    obs_wr_err_cnt += int'(wr_err);
    forever begin
      hold = 1'b0; conv_done = 1'b0; go = 1'b0; wr_en = 1'b0;
      if (nvalid < N) begin
        if (cfg_rand_hold) hold = ($urandom_range(0, 3) == 0);
        if (hold_left > 0) begin hold = 1'b1; hold_left--; end
        if (cfg_noise) begin
          go        = 1'($urandom_range(0, 1));
          conv_done = 1'($urandom_range(0, 1));
        end
        if (cfg_busy_wr_at > 0 && nvalid == cfg_busy_wr_at && !wr_done) begin
          wr_en = 1'b1; wr_addr = AW'(5); wr_data = 8'hAA; wr_done = 1;
        end
      end else if (cfg_done_delay > 0 && rel + 1 == cfg_done_delay) begin
        conv_done = 1'b1;
      end
      tick();
      cyc++;
      if (rel >= 0) rel++;
      obs_start_cnt  += int'(start_signal);
      obs_wr_err_cnt += int'(wr_err);
      if (pixel_valid) begin
        if (nvalid == 0) obs_first_cyc = cyc;
        obs_q.push_back(pixel_out);
        nvalid++;
        if (nvalid == N) rel = 0;
        if (nvalid == cfg_hold_at + 1) hold_left = cfg_hold_len;
      end else if (nvalid > 0 && nvalid < N) begin
        obs_gap++;
      end
      if (frame_done) begin obs_done_cnt++; obs_done_rel = rel; obs_busy_at_done = int'(busy); end
      if (frame_err) begin obs_err_cnt++; obs_err_rel = rel; end
      if (!busy) break;
      if (cyc > BUDGET) begin obs_timeout = 1; break; end
    end
    hold = 1'b0; conv_done = 1'b0; go = 1'b0; wr_en = 1'b0;
    repeat (2) begin
      tick();
      obs_start_cnt += int'(start_signal);
      obs_done_cnt  += int'(frame_done);
      obs_err_cnt   += int'(frame_err);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++; if (start_signal !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b expected 0", start_signal); end
    vectors++; if (pixel_out !== 8'h00) begin miscompares++; $display("FAIL reset_pixel_out: got %h expected 00", pixel_out); end
    vectors++; if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", pixel_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if ({frame_done, frame_err, wr_err} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b expected 000", {frame_done, frame_err, wr_err}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();
    vectors++; if ({busy, pixel_valid, start_signal} !== 3'b000) begin miscompares++; $display("FAIL reset_idle_after_release: got %b expected 000", {busy, pixel_valid, start_signal}); end
  endtask

  task automatic test_full_frame();
    load_frame(0);
    cfg_defaults();
    collect_frame();
    build_expected();
    vectors++; if (obs_timeout != 0) begin miscompares++; $display("FAIL full_timeout: got %0d expected 0", obs_timeout); end
    vectors++; if (obs_start_at_go != 1) begin miscompares++; $display("FAIL full_start_at_go: got %0d expected 1", obs_start_at_go); end
    vectors++; if (obs_start_cnt != 1) begin miscompares++; $display("FAIL full_start_count: got %0d expected 1", obs_start_cnt); end
    vectors++; if (obs_first_cyc != 2) begin miscompares++; $display("FAIL full_first_valid_cycle: got %0d expected 2", obs_first_cyc); end
    vectors++; if (obs_gap != 0) begin miscompares++; $display("FAIL full_gap: got %0d expected 0", obs_gap); end
    vectors++; if (obs_q.size() != N) begin miscompares++; $display("FAIL full_count: got %0d expected %0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++; if (obs_q[i] !== e) begin miscompares++; $display("FAIL full_pixel[%0d]: got %h expected %h", i, obs_q[i], e); end
    end
    vectors++; if (obs_done_rel != 4) begin miscompares++; $display("FAIL full_done_delay: got %0d expected 4", obs_done_rel); end
    vectors++; if (obs_done_cnt != 1) begin miscompares++; $display("FAIL full_done_pulses: got %0d expected 1", obs_done_cnt); end
    vectors++; if (obs_busy_at_done != 0) begin miscompares++; $display("FAIL full_busy_at_done: got %0d expected 0", obs_busy_at_done); end
    vectors++; if (obs_err_cnt != 0) begin miscompares++; $display("FAIL full_err_pulses: got %0d expected 0", obs_err_cnt); end
  endtask

  task automatic test_hold();
    cfg_defaults();
    cfg_hold_at  = 100;
    cfg_hold_len = 3;
    collect_frame();
    build_expected();
    vectors++; if (obs_gap != 3) begin miscompares++; $display("FAIL hold_gap: got %0d expected 3", obs_gap); end
    vectors++; if (obs_q.size() != N) begin miscompares++; $display("FAIL hold_count: got %0d expected %0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++; if (obs_q[i] !== e) begin miscompares++; $display("FAIL hold_pixel[%0d]: got %h expected %h", i, obs_q[i], e); end
    end
    vectors++; if (obs_done_cnt != 1) begin miscompares++; $display("FAIL hold_done_pulses: got %0d expected 1", obs_done_cnt); end
  endtask

  task automatic test_busy_write();
    cfg_defaults();
    cfg_busy_wr_at = 10;
    collect_frame();
    vectors++; if (obs_wr_err_cnt != 1) begin miscompares++; $display("FAIL busy_wr_err_pulses: got %0d expected 1", obs_wr_err_cnt); end
    cfg_defaults();
    collect_frame();
    build_expected();
    vectors++; if (obs_wr_err_cnt != 0) begin miscompares++; $display("FAIL busy_wr_err_idle: got %0d expected 0", obs_wr_err_cnt); end
    vectors++; if (obs_q.size() != N) begin miscompares++; $display("FAIL busy_count: got %0d expected %0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++; if (obs_q[i] !== e) begin miscompares++; $display("FAIL busy_pixel[%0d]: got %h expected %h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_done_timeout();
    cfg_defaults();
    cfg_done_delay = 0;
    collect_frame();
    vectors++; if (obs_timeout != 0) begin miscompares++; $display("FAIL timeout_hang: got %0d expected 0", obs_timeout); end
    vectors++; if (obs_err_rel != TIMEOUT) begin miscompares++; $display("FAIL timeout_err_delay: got %0d expected %0d", obs_err_rel, TIMEOUT); end
    vectors++; if (obs_err_cnt != 1) begin miscompares++; $display("FAIL timeout_err_pulses: got %0d expected 1", obs_err_cnt); end
    vectors++; if (obs_done_cnt != 0) begin miscompares++; $display("FAIL timeout_done_pulses: got %0d expected 0", obs_done_cnt); end
    vectors++; if (obs_q.size() != N) begin miscompares++; $display("FAIL timeout_count: got %0d expected %0d", obs_q.size(), N); end
  endtask

  task automatic test_write_with_go();
    cfg_defaults();
    cfg_wr_with_go = 1;
    cfg_wr_addr    = '0;
    cfg_wr_data    = 8'($urandom_range(128, 255));
    collect_frame();
    build_expected();
    vectors++; if (obs_wr_err_cnt != 0) begin miscompares++; $display("FAIL wrgo_wr_err: got %0d expected 0", obs_wr_err_cnt); end
    vectors++; if (obs_q.size() != N) begin miscompares++; $display("FAIL wrgo_count: got %0d expected %0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++; if (obs_q[i] !== e) begin miscompares++; $display("FAIL wrgo_pixel[%0d]: got %h expected %h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      load_frame(1);
      cfg_defaults();
      cfg_rand_hold  = 1;
      cfg_noise      = 1;
      cfg_done_delay = $urandom_range(1, 20);
      collect_frame();
      build_expected();
      vectors++; if (obs_start_cnt != 1) begin miscompares++; $display("FAIL rand_start_count: got %0d expected 1", obs_start_cnt); end
      vectors++; if (obs_done_rel != cfg_done_delay) begin miscompares++; $display("FAIL rand_done_delay: got %0d expected %0d", obs_done_rel, cfg_done_delay); end
      vectors++; if (obs_q.size() != N) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), N); end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        vectors++; if (obs_q[i] !== e) begin miscompares++; $display("FAIL rand_pixel[%0d]: got %h expected %h", i, obs_q[i], e); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, cyc, bad;
    load_frame(0);
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0; cyc = 0;
    while (n < 501 && cyc < BUDGET) begin
      tick();
      cyc++;
      if (pixel_valid) n++;
    end
    vectors++; if (n != 501) begin miscompares++; $display("FAIL midrst_reach_pixel_500: got %0d expected 501", n); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (start_signal !== 1'b0) begin miscompares++; $display("FAIL midrst_start: got %b expected 0", start_signal); end
    vectors++; if (pixel_out !== 8'h00) begin miscompares++; $display("FAIL midrst_pixel_out: got %h expected 00", pixel_out); end
    vectors++; if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", pixel_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if ({frame_done, frame_err, wr_err} !== 3'b000) begin miscompares++; $display("FAIL midrst_pulses: got %b expected 000", {frame_done, frame_err, wr_err}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (pixel_valid || busy || start_signal) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL midrst_needs_go: got %0d active cycles expected 0", bad); end
    cfg_defaults();
    collect_frame();
    build_expected();
    vectors++; if (obs_first_cyc != 2) begin miscompares++; $display("FAIL midrst_first_valid_cycle: got %0d expected 2", obs_first_cyc); end
    vectors++; if (obs_q.size() != N) begin miscompares++; $display("FAIL midrst_count: got %0d expected %0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++; if (obs_q[i] !== e) begin miscompares++; $display("FAIL midrst_pixel[%0d]: got %h expected %h", i, obs_q[i], e); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    go        = 1'b0;
    hold      = 1'b0;
    conv_done = 1'b0;
    cfg_defaults();
    test_reset();
    test_full_frame();
    test_hold();
    test_busy_write();
    test_done_timeout();
    test_write_with_go();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
